// File: rtl/tts_pkg.sv
// Shared types, defaults and helpers for the truth-table sequencer.
package tts_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StApply,
        StDone
    } tts_state_e;

    localparam int unsigned N_IN_DEF   = 3;
    localparam int unsigned SETTLE_DEF = 2;

    // Number of entries in the truth table of an n-input block.
    function automatic int unsigned table_width(input int unsigned n);
        return 32'd1 << n;
    endfunction

endpackage

// File: rtl/vector_stepper.sv
// Walks an input vector through 0 .. 2**N_IN-1, holding each value for SETTLE cycles
// and flagging the cycle whose closing edge should sample the block under test.
module vector_stepper
    import tts_pkg::*;
#(
    parameter int unsigned N_IN   = N_IN_DEF,
    parameter int unsigned SETTLE = SETTLE_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    output logic [N_IN-1:0] vec,
    output logic            sample_strobe,
    output logic            last_vec
);

    localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    if (SETTLE < 1) begin : g_bad_settle
        $error("vector_stepper: SETTLE must be at least 1");
    end
    if (N_IN < 1) begin : g_bad_n_in
        $error("vector_stepper: N_IN must be at least 1");
    end

    logic [CntW-1:0] settle_cnt_q;
    logic [N_IN-1:0] vec_q;

    // Last vector found by compare so vec never wraps inside a run.
    always_comb begin
        last_vec      = (vec_q == {N_IN{1'b1}});
        sample_strobe = run && (settle_cnt_q == CntW'(SETTLE - 1));
        vec           = vec_q;
    end

    // Settle counter and vector register; both held at zero whenever not running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_cnt_q <= '0;
            vec_q        <= '0;
        end else if (!run) begin
            settle_cnt_q <= '0;
            vec_q        <= '0;
        end else if (sample_strobe) begin
            settle_cnt_q <= '0;
            if (!last_vec) begin
                vec_q <= vec_q + N_IN'(1);
            end
        end else begin
            settle_cnt_q <= settle_cnt_q + CntW'(1);
        end
    end

endmodule

// File: rtl/truth_table_sequencer.sv
// Self-test controller: steps a small combinational block through every input vector,
// records its truth table and compares it with a supplied expected table.
module truth_table_sequencer
    import tts_pkg::*;
#(
    parameter int unsigned N_IN   = N_IN_DEF,
    parameter int unsigned SETTLE = SETTLE_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [table_width(N_IN)-1:0] expected,
    output logic [N_IN-1:0]             vec_out,
    input  logic                        dut_out,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic [table_width(N_IN)-1:0] table_out,
    output logic [N_IN:0]               fail_cnt,
    output logic [N_IN-1:0]             fail_idx
);

    localparam int unsigned TblW = table_width(N_IN);

    tts_state_e      state_q;
    logic [TblW-1:0] exp_q;
    logic [TblW-1:0] table_q;
    logic [N_IN:0]   fail_cnt_q;
    logic [N_IN-1:0] fail_idx_q;
    logic            busy_q;
    logic            done_q;
    logic            pass_q;

    logic [N_IN-1:0] vec;
    logic            sample_strobe;
    logic            last_vec;
    logic            mismatch;

    vector_stepper #(
        .N_IN   (N_IN),
        .SETTLE (SETTLE)
    ) u_stepper (
        .clk           (clk),
        .rst           (rst),
        .run           (state_q == StApply),
        .vec           (vec),
        .sample_strobe (sample_strobe),
        .last_vec      (last_vec)
    );

    // Current sample disagrees with the latched expectation.
    always_comb begin
        mismatch = (dut_out != exp_q[vec]);
    end

    // Control FSM with compare/accumulate; every output is a register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            exp_q      <= '0;
            table_q    <= '0;
            fail_cnt_q <= '0;
            fail_idx_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q    <= StApply;
                        busy_q     <= 1'b1;
                        exp_q      <= expected;
                        table_q    <= '0;
                        pass_q     <= 1'b0;
                        fail_cnt_q <= '0;
                        fail_idx_q <= '0;
                    end
                end
                StApply: begin
                    if (sample_strobe) begin
                        table_q[vec] <= dut_out;
                        if (mismatch) begin
                            fail_cnt_q <= fail_cnt_q + (N_IN + 1)'(1);
                            if (fail_cnt_q == '0) begin
                                fail_idx_q <= vec;
                            end
                        end
                        if (last_vec) begin
                            state_q <= StDone;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            // Fold in the final sample, which fail_cnt_q does not yet include.
                            pass_q  <= (fail_cnt_q == '0) && !mismatch;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign vec_out   = vec;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign table_out = table_q;
    assign fail_cnt  = fail_cnt_q;
    assign fail_idx  = fail_idx_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Scoreboard bench: stimulus pushes hand-computed results, a negedge monitor checks each done.
module tb_truth_table_sequencer;

    localparam int unsigned SETTLE_TB = 2;

    typedef struct {
        logic [7:0] tbl;
        logic       pass;
        logic [3:0] cnt;
        logic [2:0] idx;
        int         done_cyc;
    } res_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] expected;
    logic [2:0] vec_out;
    logic       dut_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] table_out;
    logic [3:0] fail_cnt;
    logic [2:0] fail_idx;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   bidx     = 0;
    bit   vec_bad  = 0;
    res_t sb[$];

    truth_table_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .expected  (expected),
        .vec_out   (vec_out),
        .dut_out   (dut_out),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .table_out (table_out),
        .fail_cnt  (fail_cnt),
        .fail_idx  (fail_idx)
    );

    // Block under test: n = (a & b) | c, with {a,b,c} = vec_out.
    assign dut_out = (vec_out[2] & vec_out[1]) | vec_out[0];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, wanted 0x%0h (cycle %0d)", name, act, exp, cyc + 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_vec_out"}, 32'(vec_out), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_pass"}, 32'(pass), 0);
        check({tag, "_table"}, 32'(table_out), 0);
        check({tag, "_fail_cnt"}, 32'(fail_cnt), 0);
        check({tag, "_fail_idx"}, 32'(fail_idx), 0);
    endtask

    // Sampling on the falling edge: the cycle number in flight is cyc + 1.
    always @(negedge clk) begin
        res_t r;
        if (rst) begin
            bidx    = 0;
            vec_bad = 0;
        end else begin
            if (busy) begin
                if (vec_out !== 3'(bidx / SETTLE_TB)) vec_bad = 1;
                bidx++;
            end
            if (done) begin
                if (sb.size() == 0) begin
                    check("spurious_done", 32'(done), 0);
                end else begin
                    r = sb.pop_front();
                    check("done_cycle", cyc + 1, r.done_cyc);
                    check("busy_cycles", bidx, 16);
                    check("vec_sequence", 32'(vec_bad), 0);
                    check("table_out", 32'(table_out), 32'(r.tbl));
                    check("pass", 32'(pass), 32'(r.pass));
                    check("fail_cnt", 32'(fail_cnt), 32'(r.cnt));
                    check("fail_idx", 32'(fail_idx), 32'(r.idx));
                end
                bidx    = 0;
                vec_bad = 0;
            end
        end
    end

    // Raise start for one edge; returns the accepting edge number.
    task automatic pulse_start(input logic [7:0] exp_tbl, output int k);
        @(negedge clk);
        expected = exp_tbl;
        start    = 1'b1;
        @(posedge clk);
        #1 k = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic push(input logic [7:0] tbl, input logic p, input logic [3:0] cnt,
                        input logic [2:0] idx, input int done_cyc);
        res_t r;
        r.tbl = tbl; r.pass = p; r.cnt = cnt; r.idx = idx; r.done_cyc = done_cyc;
        sb.push_back(r);
    endtask

    task automatic wait_drain();
        int t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("drain_timeout", sb.size(), 0);
        sb.delete();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int k;
        int t;
        rst      = 1'b1;
        start    = 1'b0;
        expected = 8'h00;
        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);

        // Pass run with an ignored mid-run pulse, then start held into a fail run
        // whose expected table changed while the first run was busy.
        pulse_start(8'hEA, k);
        push(8'hEA, 1'b1, 4'd0, 3'd0, k + 17);
        while (cyc != k + 4) @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        while (cyc != k + 10) @(negedge clk);
        expected = 8'h2A;
        start    = 1'b1;
        push(8'hEA, 1'b0, 4'd2, 3'd6, k + 35);
        while (cyc != k + 17) @(negedge clk);
        check("idle_gap_busy", 32'(busy), 0);
        check("idle_gap_pass", 32'(pass), 1);
        check("idle_gap_table", 32'(table_out), 32'hEA);
        while (cyc != k + 18) @(negedge clk);
        check("restart_busy", 32'(busy), 1);
        while (cyc != k + 20) @(negedge clk);
        start = 1'b0;
        wait_drain();

        // Every vector mismatches.
        pulse_start(8'h15, k);
        push(8'hEA, 1'b0, 4'd8, 3'd0, k + 17);
        wait_drain();

        // Asynchronous reset between edges while vector 3 is applied.
        pulse_start(8'hEA, k);
        push(8'hEA, 1'b1, 4'd0, 3'd0, k + 17);
        t = 0;
        while (vec_out !== 3'd3 && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("reach_vec3", 32'(vec_out), 3);
        sb.delete();
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_rst");
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);

        // Full run after the aborted one.
        pulse_start(8'hEA, k);
        push(8'hEA, 1'b1, 4'd0, 3'd0, k + 17);
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
